// File: rtl/fft_addr_gen.sv
// Address sequencer for an in-place radix-2 DIT FFT: bit-reversed load, per-stage butterfly pairs, natural unload (twiddle index under FFT_ADDR_TWIDDLE_EN).
// Latency: every output is registered one cycle behind the inputs that cause it; write-back trails its operand read by WR_LAT cycles.
// Backpressure: in_valid gates LOAD and out_ready gates UNLOAD; COMPUTE never stalls.
module fft_addr_gen #(
  parameter int LOG2N  = 7,
  parameter int WR_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr,
  output logic [3:0]       stage,
  output logic             bf_lower,
  output logic [LOG2N-2:0] tw_addr
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_UNLOAD  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [LOG2N-1:0] ONE        = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] LAST       = {LOG2N{1'b1}};
  localparam logic [3:0]       LAST_STAGE = 4'(LOG2N-1);
  localparam logic [3:0]       DRAIN_LAST = 4'(WR_LAT-1);

  logic [2:0]       state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [3:0]       s_q, s_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d, lower_q, lower_d;
  logic [LOG2N-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [3:0]       stage_q, stage_d;
  logic             load_wr;
  logic [LOG2N-1:0] load_addr;
  logic             wb_in_vld;
  logic             wb_vld_q  [WR_LAT];
  logic [LOG2N-1:0] wb_addr_q [WR_LAT];
  logic [LOG2N-1:0] k_ext, mask, top_addr, bf_addr;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  // cnt_q = {k, half}: half selects the top (0) or bottom (1) operand of butterfly k
  assign k_ext    = {1'b0, cnt_q[LOG2N-1:1]};
  assign mask     = (ONE << s_q) - ONE;
  assign top_addr = ((k_ext >> s_q) << (s_q + 4'd1)) | (k_ext & mask);
  assign bf_addr  = cnt_q[0] ? (top_addr + (ONE << s_q)) : top_addr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s_d       = s_q;
    dcnt_d    = dcnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    lower_d   = 1'b0;
    load_wr   = 1'b0;
    load_addr = '0;
    wb_in_vld = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // done_q still high means this is the cycle that shows the done pulse
        if (start && !done_q) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          load_wr   = 1'b1;
          load_addr = bitrev(cnt_q);
          cnt_d     = cnt_q + ONE;
          if (cnt_q == LAST) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
            s_d     = '0;
          end
        end
      end
      S_COMPUTE: begin
        rd_en_d   = 1'b1;
        rd_addr_d = bf_addr;
        lower_d   = cnt_q[0];
        wb_in_vld = 1'b1;
        cnt_d     = cnt_q + ONE;
        if (cnt_q == LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        dcnt_d = dcnt_q + 4'd1;
        if (dcnt_q == DRAIN_LAST) begin
          dcnt_d = '0;
          if (s_q == LAST_STAGE) begin
            state_d = S_UNLOAD;
            s_d     = '0;
          end else begin
            state_d = S_COMPUTE;
            s_d     = s_q + 4'd1;
          end
        end
      end
      S_UNLOAD: begin
        if (out_ready) begin
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q;
          cnt_d     = cnt_q + ONE;
          if (cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stage_d   = (state_q == S_COMPUTE || state_q == S_DRAIN) ? s_q : 4'd0;
    wr_en_d   = load_wr | wb_vld_q[WR_LAT-1];
    wr_addr_d = wr_addr_q;
    if (load_wr)                    wr_addr_d = load_addr;
    else if (wb_vld_q[WR_LAT-1])    wr_addr_d = wb_addr_q[WR_LAT-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      s_q       <= '0;
      dcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      lower_q   <= 1'b0;
      stage_q   <= '0;
      for (int i = 0; i < WR_LAT; i++) begin
        wb_vld_q[i]  <= 1'b0;
        wb_addr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      s_q       <= s_d;
      dcnt_q    <= dcnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      lower_q   <= lower_d;
      stage_q   <= stage_d;
      // stage 0 is loaded in step with rd_addr_q, so the tail lags the read by WR_LAT once re-registered
      wb_vld_q[0]  <= wb_in_vld;
      wb_addr_q[0] <= rd_addr_d;
      for (int i = 1; i < WR_LAT; i++) begin
        wb_vld_q[i]  <= wb_vld_q[i-1];
        wb_addr_q[i] <= wb_addr_q[i-1];
      end
    end
  end

`ifdef FFT_ADDR_TWIDDLE_EN
  logic [LOG2N-2:0] tw_q, tw_d;
  logic [LOG2N-2:0] k_tw;

  assign k_tw = cnt_q[LOG2N-1:1];

  always_comb begin
    tw_d = '0;
    if (state_q == S_COMPUTE)
      tw_d = cnt_q[0] ? tw_q : ((k_tw & mask[LOG2N-2:0]) << (LAST_STAGE - s_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tw_q <= '0;
    else     tw_q <= tw_d;
  end

  assign tw_addr = tw_q;
`else
  assign tw_addr = '0;
`endif

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign stage    = stage_q;
  assign bf_lower = lower_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Bench for fft_addr_gen: timeline model of a whole transform built from the sequencing rules, compared every cycle.
module tb_fft_addr_gen;
  localparam int LOG2N  = 3;
  localparam int WR_LAT = 2;
  localparam int N      = 1 << LOG2N;
  localparam int MAXS   = 256;
  localparam int DEF_CYC = 7 * (128 + 2);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic busy, done, rd_en, wr_en, bf_lower;
  logic [LOG2N-1:0] rd_addr, wr_addr;
  logic [3:0]       stage;
  logic [LOG2N-2:0] tw_addr;

  logic d_start = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b0;
  logic d_busy, d_done, d_rd_en, d_wr_en, d_lower;
  logic [6:0] d_rd_addr, d_wr_addr;
  logic [3:0] d_stage;
  logic [5:0] d_tw;

  fft_addr_gen #(.LOG2N(LOG2N), .WR_LAT(WR_LAT)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .stage(stage), .bf_lower(bf_lower), .tw_addr(tw_addr));

  fft_addr_gen u_def (
    .clk(clk), .rst(rst), .start(d_start), .in_valid(d_in_valid), .out_ready(d_out_ready),
    .busy(d_busy), .done(d_done), .rd_en(d_rd_en), .rd_addr(d_rd_addr), .wr_en(d_wr_en),
    .wr_addr(d_wr_addr), .stage(d_stage), .bf_lower(d_lower), .tw_addr(d_tw));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // expected output values per slot (slot e = what is visible after edge e; edge 0 samples start)
  int x_busy[MAXS], x_done[MAXS], x_rd_en[MAXS], x_rd_addr[MAXS], x_wr_en[MAXS];
  int x_wr_addr[MAXS], x_stage[MAXS], x_lower[MAXS], x_tw[MAXS];
  int iv[MAXS], orr[MAXS], st_in[MAXS];
  int last_slot, e_load_end, e_unload, e_done;
  int hold_rd = 0, hold_wr = 0;
  logic cmp_on = 1'b0;
  int cmp_slot = 0;

  int lit_load[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int lit_st1[8]  = '{0, 2, 1, 3, 4, 6, 5, 7};
  int lit_st2[8]  = '{0, 4, 1, 5, 2, 6, 3, 7};
  int lit_tw2[8]  = '{0, 0, 1, 1, 2, 2, 3, 3};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_lower"}, bf_lower, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_tw"}, tw_addr, 0);
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LOG2N; i++)
      if ((x >> i) & 1) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  // mode 0: all handshakes high; 1: in_valid toggles, out_ready has 3-cycle gaps; 2: random
  task automatic build_model(input int mode);
    int acc, u, e, prv;
    for (int i = 0; i < MAXS; i++) begin
      x_busy[i] = 0; x_done[i] = 0; x_rd_en[i] = 0; x_rd_addr[i] = 0; x_wr_en[i] = 0;
      x_wr_addr[i] = 0; x_stage[i] = 0; x_lower[i] = 0; x_tw[i] = 0;
      st_in[i] = 0;
      iv[i]  = (mode == 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 1)) : 0;
      orr[i] = (mode == 0) ? 1 : (mode == 2) ? int'($urandom_range(0, 1)) : 0;
    end
    acc = 0; e = 0;
    while (acc < N) begin
      e++;
      if (mode == 1)      iv[e] = e % 2;
      else if (mode == 2) iv[e] = (e > 60) ? 1 : int'($urandom_range(0, 2) != 0);
      if (iv[e] != 0) begin
        x_wr_en[e] = 1; x_wr_addr[e] = brev(acc); acc++;
      end
    end
    e_load_end = e;
    for (int st = 0; st < LOG2N; st++) begin
      int h, s0, k;
      h = 1 << st; s0 = e_load_end + 1 + st * (N + WR_LAT); k = 0;
      for (int i = 0; i < N + WR_LAT; i++) x_stage[s0 + i] = st;
      for (int b = 0; b < N; b += 2 * h)
        for (int j = 0; j < h; j++) begin
          int sl;
          sl = s0 + 2 * k;
          for (int lo = 0; lo < 2; lo++) begin
            x_rd_en[sl + lo] = 1; x_rd_addr[sl + lo] = b + j + lo * h;
            x_lower[sl + lo] = lo; x_tw[sl + lo] = j << (LOG2N - 1 - st);
            x_wr_en[sl + lo + WR_LAT] = 1; x_wr_addr[sl + lo + WR_LAT] = b + j + lo * h;
          end
          k++;
        end
    end
    e_unload = e_load_end + LOG2N * (N + WR_LAT) + 1;
    u = 0; e = e_unload - 1;
    while (u < N) begin
      e++;
      if (mode == 1)      orr[e] = ((e - e_unload) < 3 || ((e - e_unload) >= 5 && (e - e_unload) < 8)) ? 0 : 1;
      else if (mode == 2) orr[e] = (e - e_unload > 40) ? 1 : int'($urandom_range(0, 1));
      if (orr[e] != 0) begin
        x_rd_en[e] = 1; x_rd_addr[e] = u; u++;
      end
    end
    e_done = e;
    x_done[e_done + 1] = 1;
    for (int i = 0; i <= e_done; i++) x_busy[i] = 1;
    last_slot = e_done + 4;
    st_in[0] = 1;
    if (mode == 2)
      for (int i = 1; i <= e_done; i++) st_in[i] = int'($urandom_range(0, 7) == 0);
    st_in[e_done + 1] = 1;
    st_in[e_done + 2] = 1;
    // addresses keep their last value whenever their strobe is low
    prv = hold_rd;
    for (int i = 0; i <= last_slot; i++) begin
      if (x_rd_en[i] == 0) x_rd_addr[i] = prv;
      prv = x_rd_addr[i];
    end
    prv = hold_wr;
    for (int i = 0; i <= last_slot; i++) begin
      if (x_wr_en[i] == 0) x_wr_addr[i] = prv;
      prv = x_wr_addr[i];
    end
  endtask

  task automatic pin_model();
    for (int i = 0; i < N; i++) begin
      check($sformatf("pin_load%0d", i), x_wr_addr[1 + i], lit_load[i]);
      check($sformatf("pin_st1_%0d", i), x_rd_addr[e_load_end + 1 + (N + WR_LAT) + i], lit_st1[i]);
      check($sformatf("pin_st2_%0d", i), x_rd_addr[e_load_end + 1 + 2 * (N + WR_LAT) + i], lit_st2[i]);
      check($sformatf("pin_tw2_%0d", i), x_tw[e_load_end + 1 + 2 * (N + WR_LAT) + i], lit_tw2[i]);
    end
    check("pin_compute_cycles", e_unload - e_load_end - 1, 30);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check($sformatf("busy@%0d", cmp_slot), busy, x_busy[cmp_slot]);
      check($sformatf("done@%0d", cmp_slot), done, x_done[cmp_slot]);
      check($sformatf("rd_en@%0d", cmp_slot), rd_en, x_rd_en[cmp_slot]);
      check($sformatf("rd_addr@%0d", cmp_slot), rd_addr, x_rd_addr[cmp_slot]);
      check($sformatf("wr_en@%0d", cmp_slot), wr_en, x_wr_en[cmp_slot]);
      check($sformatf("wr_addr@%0d", cmp_slot), wr_addr, x_wr_addr[cmp_slot]);
      check($sformatf("stage@%0d", cmp_slot), stage, x_stage[cmp_slot]);
      check($sformatf("bf_lower@%0d", cmp_slot), bf_lower, x_lower[cmp_slot]);
`ifdef FFT_ADDR_TWIDDLE_EN
      check($sformatf("tw@%0d", cmp_slot), tw_addr, x_tw[cmp_slot]);
`else
      check($sformatf("tw@%0d", cmp_slot), tw_addr, 0);
`endif
    end
  end

  task automatic run_transform(input int mode, input bit abort, input bit pin);
    int abort_slot;
    build_model(mode);
    if (pin) pin_model();
    abort_slot = abort ? e_load_end + 1 + (N + WR_LAT) + 3 : -1;
    for (int e = 0; e <= last_slot; e++) begin
      @(negedge clk);
      start = (st_in[e] != 0); in_valid = (iv[e] != 0); out_ready = (orr[e] != 0);
      @(posedge clk);
      if (e == abort_slot) begin
        cmp_on = 1'b0;
        check("abort_pre_stage", stage, 1);
        #2 rst = 1'b1;
        #1 check_zero("abort_async");
        @(negedge clk);
        check_zero("abort_next");
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold_rd = 0; hold_wr = 0;
        return;
      end
      cmp_slot = e; cmp_on = 1'b1;
    end
    @(negedge clk);
    #1 cmp_on = 1'b0;
    start = 1'b0;
    hold_rd = x_rd_addr[last_slot]; hold_wr = x_wr_addr[last_slot];
  endtask

  initial begin
    int n_rd, n_wr, n_done, first, unl;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("idle");

    run_transform(0, 1'b0, 1'b1);
    run_transform(1, 1'b0, 1'b0);
    run_transform(2, 1'b1, 1'b0);
    run_transform(0, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) run_transform(2, 1'b0, 1'b0);

    d_in_valid = 1'b1; d_out_ready = 1'b1;
    @(negedge clk); d_start = 1'b1;
    @(negedge clk); d_start = 1'b0;
    n_rd = 0; n_wr = 0; n_done = 0; first = -1; unl = -1;
    for (int c = 0; c < 1400; c++) begin
      if (d_rd_en) begin
        if (n_rd == 0) first = c;
        if (n_rd == 7 * 128) unl = c;
        n_rd++;
      end
      if (d_wr_en) n_wr++;
      if (d_done) n_done++;
      @(negedge clk);
    end
    check("def_reads", n_rd, 1024);
    check("def_writes", n_wr, 1024);
    check("def_compute_cycles", unl - first, DEF_CYC);
    check("def_done_pulses", n_done, 1);
    check("def_busy_end", d_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
